// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen
//   Conditions two raw, bouncing, asynchronous push-buttons (set request and
//   reset request) into clean synchronous pulses for a downstream SR latch.
//   The s and r outputs are never high in the same cycle.
//   Each channel is processed in this order:
//     synchroniser -> debounce -> rising-edge detect -> one-deep pending slot
//   A small FSM then turns the pending requests into pulses, one at a time.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   set_btn   in   raw set button (asynchronous, may bounce)
//   rst_btn   in   raw reset button (asynchronous, may bounce)
//   s         out  set pulse, registered, PULSE_WIDTH cycles per request
//   r         out  reset pulse, registered, PULSE_WIDTH cycles per request
//   busy      out  high while an s or r pulse is in progress
//   conflict  out  one-cycle flag: simultaneous set+reset requests discarded
//
// Handshake note: there is no valid/ready pairing here. A request is a single
// rising edge of the debounced level. It waits in its one-deep slot until the
// FSM is idle. A second request that arrives while the slot is still full is
// dropped silently.

module sr_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_WIDTH     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2
  } state_t;

  // Index 0 is the set channel. Index 1 is the reset channel.
  logic [SYNC_STAGES-1:0] set_sync;
  logic [SYNC_STAGES-1:0] rst_sync;
  logic [1:0]             sync_out;
  logic [1:0]             db;
  logic [1:0]             db_d;
  logic [CW-1:0]          cnt [2];
  logic [1:0]             rise;

  logic                   set_pend;
  logic                   rst_pend;
  logic                   set_take;
  logic                   rst_take;

  state_t                 state;
  logic [PCW-1:0]         pcnt;

  // Synchronisers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_sync <= '0;
      rst_sync <= '0;
    end else begin
      set_sync <= {set_sync[SYNC_STAGES-2:0], set_btn};
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], rst_btn};
    end
  end

  assign sync_out = {rst_sync[SYNC_STAGES-1], set_sync[SYNC_STAGES-1]};

  // Debounce. The counter runs only while the synchronised input disagrees
  // with the accepted level, and any agreement restarts it. The level flips
  // on the cycle that would bring the count to DEBOUNCE_CYCLES. That means
  // the stored count never actually holds DEBOUNCE_CYCLES and cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db   <= '0;
      db_d <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        cnt[ch] <= '0;
      end
    end else begin
      db_d <= db;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync_out[ch] != db[ch]) begin
          if (cnt[ch] == CW'(DEBOUNCE_CYCLES - 1)) begin
            db[ch]  <= sync_out[ch];
            cnt[ch] <= '0;
          end else begin
            cnt[ch] <= cnt[ch] + 1'b1;
          end
        end else begin
          cnt[ch] <= '0;
        end
      end
    end
  end

  // Only the 0->1 transition of the debounced level counts as a request.
  assign rise = db & ~db_d;

  // The FSM consumes a slot only from IDLE.
  assign set_take = (state == IDLE) & set_pend;
  assign rst_take = (state == IDLE) & rst_pend;

  // A slot can only be consumed while it is full, and a new request is only
  // accepted into an empty slot. The two updates therefore never target the
  // same cycle's content, and a request that meets a full slot is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_pend <= 1'b0;
      rst_pend <= 1'b0;
    end else begin
      set_pend <= (set_pend & ~set_take) | (rise[0] & ~set_pend);
      rst_pend <= (rst_pend & ~rst_take) | (rise[1] & ~rst_pend);
    end
  end

  // Pulse FSM. Every output is registered here. After each pulse the FSM
  // returns to IDLE for at least one cycle, and that guarantees a low cycle
  // between consecutive pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          if (set_pend && rst_pend) begin
            conflict <= 1'b1;
          end else if (set_pend) begin
            state <= SET_P;
            pcnt  <= '0;
            s     <= 1'b1;
            busy  <= 1'b1;
          end else if (rst_pend) begin
            state <= RST_P;
            pcnt  <= '0;
            r     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        SET_P, RST_P: begin
          if (pcnt == PCW'(PULSE_WIDTH - 1)) begin
            state <= IDLE;
            s     <= 1'b0;
            r     <= 1'b0;
            busy  <= 1'b0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          s     <= 1'b0;
          r     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
